// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bus of the immediate generator.
//   Producer side : in_valid, in_instr -> block; in_ready <- block.
//   Consumer side : out_valid, out_imm, out_fmt, out_instr <- block;
//                   out_ready -> block.
//   master modport: the environment driving instructions and consuming
//                   results.
//   slave modport : the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [31:0]     out_instr;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_instr
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_instr
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V RV32I immediate generator with a result FIFO.
//   Decodes the immediate of each accepted 32-bit instruction word
//   (I, S, B, U, J formats), sign-extends it to XLEN and buffers
//   {imm, fmt, instr} in a DEPTH-entry FIFO.
// Parameters:
//   XLEN  - immediate width, 32 or 64.
//   DEPTH - FIFO entries, power of two, >= 2.
// Ports:
//   clk            rising-edge clock.
//   rst            asynchronous active-high reset.
//   flush          synchronous discard of all buffered entries.
//   bus (slave)    in_valid/in_ready/in_instr input handshake,
//                  out_valid/out_ready/out_imm/out_fmt/out_instr output.
//   perf_imm_cnt   popped entries with fmt != NONE.
//   perf_none_cnt  popped entries with fmt == NONE.
// Build option:
//   IMMGEN_PERF_EN - when defined the perf counters are live; otherwise
//                    both perf ports are tied to 0.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus,
    output logic [31:0]   perf_imm_cnt,
    output logic [31:0]   perf_none_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // Size cast of a signed operand replicates its sign bit.
    function automatic logic signed [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // ---- stage p0: combinational decode of the incoming word ----
    logic [31:0]            ins;
    logic signed [31:0]     imm32_p0;
    logic signed [XLEN-1:0] imm_p0;
    fmt_e                   fmt_p0;

    assign ins = bus.in_instr;

    always_comb begin
        imm32_p0 = '0;
        fmt_p0   = FMT_NONE;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                fmt_p0   = FMT_I;
                imm32_p0 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                fmt_p0   = FMT_S;
                imm32_p0 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                fmt_p0   = FMT_B;
                imm32_p0 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_p0   = FMT_U;
                imm32_p0 = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_p0   = FMT_J;
                imm32_p0 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: begin
                fmt_p0   = FMT_NONE;
                imm32_p0 = '0;
            end
        endcase
    end

    assign imm_p0 = sext(imm32_p0);

    // ---- stage p1: FIFO storage and head ----
    logic signed [XLEN-1:0] imm_mem   [DEPTH];
    fmt_e                   fmt_mem   [DEPTH];
    logic [31:0]            instr_mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          vld_p1;
    logic          push;
    logic          pop;

    // count never exceeds DEPTH = 2**AW, so its MSB alone flags full.
    assign full   = count[AW];
    assign vld_p1 = (count != '0);

    // Flush wins over any same-cycle transfer; ready is purely state-based,
    // so a pop never frees a slot for a push in the same cycle.
    assign push = bus.in_valid & ~full & ~flush;
    assign pop  = vld_p1 & bus.out_ready & ~flush;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = vld_p1;
    assign bus.out_imm   = imm_mem[rptr];
    assign bus.out_fmt   = fmt_mem[rptr];
    assign bus.out_instr = instr_mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is reset too so the head outputs read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i]   <= '0;
                fmt_mem[i]   <= FMT_NONE;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            imm_mem[wptr]   <= imm_p0;
            fmt_mem[wptr]   <= fmt_p0;
            instr_mem[wptr] <= ins;
        end
    end

    // ---- stage p2: pop-side performance counters ----
`ifdef IMMGEN_PERF_EN
    logic [31:0] imm_cnt;
    logic [31:0] none_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_cnt  <= '0;
            none_cnt <= '0;
        end else if (pop) begin
            if (fmt_mem[rptr] != FMT_NONE) begin
                imm_cnt <= imm_cnt + 32'd1;
            end else begin
                none_cnt <= none_cnt + 32'd1;
            end
        end
    end

    assign perf_imm_cnt  = imm_cnt;
    assign perf_none_cnt = none_cnt;
`else
    assign perf_imm_cnt  = '0;
    assign perf_none_cnt = '0;
`endif
endmodule
